tucanos_scheduler: RTL and testbench

Process scheduler sitting directly downstream of the watchdog. It consumes the watchdog's `jump_enabler`/`state_register` event and saves the interrupted program counter. It updates a three-entry process status table and selects the next process round-robin. It then emits a one-cycle dispatch with the resume address for the OS jump logic.

---
 rtl/tucanos_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tucanos_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tucanos_scheduler.sv
// Round-robin process scheduler downstream of the watchdog: saves the interrupted
// PC, updates the three-entry status table and emits a one-cycle dispatch.
module tucanos_scheduler #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] PROC1_START = 12'd16,
  parameter logic [ADDR_WIDTH-1:0] PROC2_START = 12'd96,
  parameter logic [ADDR_WIDTH-1:0] PROC3_START = 12'd176
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  jump_enabler,
  input  logic [DATA_WIDTH-1:0] state_register,
  input  logic [ADDR_WIDTH-1:0] program_counter,
  input  logic                  io_done,
  input  logic [1:0]            io_process,
  output logic [1:0]            current_process,
  output logic [ADDR_WIDTH-1:0] resume_pc,
  output logic                  dispatch_valid,
  output logic [5:0]            process_status,
  output logic                  all_halted,
  output logic                  event_dropped
);

  typedef enum logic [2:0] {S_IDLE, S_SAVE, S_SELECT, S_DISPATCH, S_DONE} state_t;

  localparam logic [1:0] ST_READY   = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_WAITING = 2'b10;
  localparam logic [1:0] ST_HALTED  = 2'b11;

  state_t                r_state;
  logic                  r_jump_q;
  logic [1:0]            r_req;
  logic                  r_wait;
  logic                  r_halt;
  logic [ADDR_WIDTH-1:0] r_lpc;
  logic [ADDR_WIDTH-1:0] r_saved [1:3];
  logic [1:0]            r_status [1:3];
  logic [1:0]            r_chosen;

  logic                  w_event;
  logic [1:0]            w_req;
  logic [1:0]            w_base;
  logic [1:0]            w_cand [0:2];
  logic                  w_found;
  logic [1:0]            w_pick;
  logic                  w_any_wait;
  logic [1:0]            w_save_status;

  assign w_event        = jump_enabler & ~r_jump_q;
  assign process_status = {r_status[3], r_status[2], r_status[1]};

  always_comb begin
    w_req = 2'd0;
    if (state_register == DATA_WIDTH'(1))      w_req = 2'd1;
    else if (state_register == DATA_WIDTH'(2)) w_req = 2'd2;
    else if (state_register == DATA_WIDTH'(3)) w_req = 2'd3;
  end

  always_comb begin
    w_save_status = ST_READY;
    if (r_wait)      w_save_status = ST_WAITING;
    else if (r_halt) w_save_status = ST_HALTED;
  end

  // A request names the first candidate; otherwise rotate starting after the current process.
  always_comb begin
    w_cand[0]  = 2'd1;
    w_cand[1]  = 2'd2;
    w_cand[2]  = 2'd3;
    w_base     = (r_req != 2'd0) ? (r_req - 2'd1) : current_process;
    case (w_base)
      2'd1: begin w_cand[0] = 2'd2; w_cand[1] = 2'd3; w_cand[2] = 2'd1; end
      2'd2: begin w_cand[0] = 2'd3; w_cand[1] = 2'd1; w_cand[2] = 2'd2; end
      default: ;
    endcase
    w_found    = 1'b0;
    w_pick     = 2'd0;
    w_any_wait = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (r_status[w_cand[i]] == ST_READY) begin
        w_found = 1'b1;
        w_pick  = w_cand[i];
      end
    end
    for (int p = 1; p <= 3; p++) begin
      if (r_status[p] == ST_WAITING) w_any_wait = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_jump_q        <= 1'b0;
      r_req           <= 2'd0;
      r_wait          <= 1'b0;
      r_halt          <= 1'b0;
      r_lpc           <= '0;
      r_chosen        <= 2'd0;
      r_saved[1]      <= PROC1_START;
      r_saved[2]      <= PROC2_START;
      r_saved[3]      <= PROC3_START;
      r_status[1]     <= ST_READY;
      r_status[2]     <= ST_READY;
      r_status[3]     <= ST_READY;
      current_process <= 2'd0;
      resume_pc       <= '0;
      dispatch_valid  <= 1'b0;
      all_halted      <= 1'b0;
      event_dropped   <= 1'b0;
    end else begin
      r_jump_q       <= jump_enabler;
      dispatch_valid <= 1'b0;
      if (w_event && (r_state != S_IDLE)) event_dropped <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            r_req   <= w_req;
            r_wait  <= (state_register == DATA_WIDTH'(4));
            r_halt  <= (state_register == DATA_WIDTH'(5));
            r_lpc   <= program_counter;
            r_state <= S_SAVE;
          end
        end
        S_SAVE: begin
          if (current_process != 2'd0) begin
            r_saved[current_process]  <= r_lpc;
            r_status[current_process] <= w_save_status;
          end
          r_state <= S_SELECT;
        end
        S_SELECT: begin
          if (w_found) begin
            r_chosen <= w_pick;
            r_state  <= S_DISPATCH;
          end else if (!w_any_wait) begin
            all_halted <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DISPATCH: begin
          r_status[r_chosen] <= ST_RUNNING;
          current_process    <= r_chosen;
          resume_pc          <= r_saved[r_chosen];
          dispatch_valid     <= 1'b1;
          r_state            <= S_IDLE;
        end
        default: r_state <= S_DONE;
      endcase

      // I/O completion also beats a same-edge SAVE that parks the same process in WAITING.
      if (io_done && (io_process != 2'd0) &&
          ((r_status[io_process] == ST_WAITING) ||
           ((r_state == S_SAVE) && r_wait && (io_process == current_process))))
        r_status[io_process] <= ST_READY;
    end
  end

endmodule

// File: tb/tb_tucanos_scheduler.sv
// Bench for tucanos_scheduler: directed scenarios with literal expectations,
// then random stimulus compared every cycle against a behavioural model.
module tb_tucanos_scheduler;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int READY = 0, RUN = 1, WAIT = 2, HALT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          jump_enabler = 1'b0;
  logic [DW-1:0] state_register = '0;
  logic [AW-1:0] program_counter = '0;
  logic          io_done = 1'b0;
  logic [1:0]    io_process = 2'd0;
  logic [1:0]    current_process;
  logic [AW-1:0] resume_pc;
  logic          dispatch_valid;
  logic [5:0]    process_status;
  logic          all_halted;
  logic          event_dropped;

  tucanos_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .PROC1_START(12'd16), .PROC2_START(12'd96), .PROC3_START(12'd176)
  ) dut (
    .clock(clock), .reset(reset), .jump_enabler(jump_enabler),
    .state_register(state_register), .program_counter(program_counter),
    .io_done(io_done), .io_process(io_process),
    .current_process(current_process), .resume_pc(resume_pc),
    .dispatch_valid(dispatch_valid), .process_status(process_status),
    .all_halted(all_halted), .event_dropped(event_dropped)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: a phase number plus process tables as plain ints.
  int m_phase = 0;
  int m_st [1:3];
  int m_pc [1:3];
  int m_cur = 0, m_rpc = 0, m_dv = 0, m_halt = 0, m_drop = 0;
  int m_jprev = 0, m_code = 0, m_lpc = 0, m_chosen = 0;

  task automatic model_reset();
    m_phase = 0;
    for (int p = 1; p <= 3; p++) m_st[p] = READY;
    m_pc[1] = 16; m_pc[2] = 96; m_pc[3] = 176;
    m_cur = 0; m_rpc = 0; m_dv = 0; m_halt = 0; m_drop = 0;
    m_jprev = 0; m_code = 0; m_lpc = 0; m_chosen = 0;
  endtask

  task automatic model_step();
    int  ph0;
    int  base;
    int  c;
    int  cand;
    bit  ev;
    bit  any_wait;
    ph0     = m_phase;
    ev      = (jump_enabler == 1'b1) && (m_jprev == 0);
    m_jprev = int'(jump_enabler);
    m_dv    = 0;
    if (ev && ph0 != 0) m_drop = 1;
    case (ph0)
      0: if (ev) begin
           m_code  = int'(state_register);
           m_lpc   = int'(program_counter);
           m_phase = 1;
         end
      1: begin
           if (m_cur != 0) begin
             m_pc[m_cur] = m_lpc;
             m_st[m_cur] = (m_code == 4) ? WAIT : (m_code == 5) ? HALT : READY;
           end
           m_phase = 2;
         end
      2: begin
           base = (m_code >= 1 && m_code <= 3) ? m_code - 1 : m_cur % 3;
           c = 0;
           any_wait = 0;
           for (int k = 1; k <= 3; k++) begin
             cand = (base + k - 1) % 3 + 1;
             if (c == 0 && m_st[cand] == READY) c = cand;
             if (m_st[k] == WAIT) any_wait = 1;
           end
           if (c != 0) begin
             m_chosen = c;
             m_phase  = 3;
           end else if (!any_wait) begin
             m_halt  = 1;
             m_phase = 4;
           end
         end
      3: begin
           m_st[m_chosen] = RUN;
           m_cur   = m_chosen;
           m_rpc   = m_pc[m_chosen];
           m_dv    = 1;
           m_phase = 0;
         end
      default: ;
    endcase
    if (io_done && io_process != 2'd0 && m_st[io_process] == WAIT) m_st[io_process] = READY;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(posedge clock) begin
    #1;
    chk("current_process", 32'(current_process), m_cur);
    chk("resume_pc", 32'(resume_pc), m_rpc);
    chk("dispatch_valid", 32'(dispatch_valid), m_dv);
    chk("process_status", 32'(process_status), m_st[1] + (m_st[2] << 2) + (m_st[3] << 4));
    chk("all_halted", 32'(all_halted), m_halt);
    chk("event_dropped", 32'(event_dropped), m_drop);
  end

  task automatic ev_pulse(input int code, input int pc);
    @(negedge clock);
    jump_enabler    = 1'b1;
    state_register  = 32'(code);
    program_counter = 12'(pc);
    @(negedge clock);
    jump_enabler    = 1'b0;
  endtask

  // Edges until dispatch_valid is seen; max+1 means none within the budget.
  task automatic wait_dv(input int max, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (n < max && !seen) begin
      @(posedge clock);
      #1;
      n++;
      if (dispatch_valid) seen = 1;
    end
    if (!seen) n = max + 1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cur"}, 32'(current_process), 0);
    chk({tag, "_rpc"}, 32'(resume_pc), 0);
    chk({tag, "_dv"}, 32'(dispatch_valid), 0);
    chk({tag, "_status"}, 32'(process_status), 0);
    chk({tag, "_halted"}, 32'(all_halted), 0);
    chk({tag, "_dropped"}, 32'(event_dropped), 0);
  endtask

  initial begin
    int n;
    int cnt;
    repeat (3) @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b0;

    ev_pulse(1, 0);
    wait_dv(8, n);
    chk("first_latency", n, 3);
    chk("first_cur", 32'(current_process), 1);
    chk("first_rpc", 32'(resume_pc), 16);
    chk("first_status", 32'(process_status), 32'b000001);

    ev_pulse(2, 40);
    wait_dv(8, n);
    chk("rr_p2_cur", 32'(current_process), 2);
    chk("rr_p2_rpc", 32'(resume_pc), 96);
    chk("rr_p2_status", 32'(process_status), 32'b000100);

    ev_pulse(1, 50);
    wait_dv(8, n);
    chk("rr_p1_cur", 32'(current_process), 1);
    chk("rr_p1_rpc", 32'(resume_pc), 40);

    ev_pulse(5, 0);
    wait_dv(8, n);
    chk("halt_p1_rpc", 32'(resume_pc), 50);
    chk("halt_p1_status", 32'(process_status), 32'b000111);

    ev_pulse(3, 60);
    wait_dv(8, n);
    chk("p3_rpc", 32'(resume_pc), 176);
    chk("p3_status", 32'(process_status), 32'b010011);

    ev_pulse(5, 0);
    wait_dv(8, n);
    chk("halt_p3_cur", 32'(current_process), 2);
    chk("halt_p3_rpc", 32'(resume_pc), 60);

    ev_pulse(4, 100);
    wait_dv(6, n);
    chk("stall_no_dispatch", n, 7);
    chk("stall_status", 32'(process_status), 32'b111011);
    @(negedge clock); io_done = 1'b1; io_process = 2'd1;
    @(negedge clock); io_process = 2'd0;
    @(negedge clock); io_process = 2'd2;
    chk("ignored_io_status", 32'(process_status), 32'b111011);
    chk("ignored_io_dv", 32'(dispatch_valid), 0);
    @(negedge clock); io_done = 1'b0; io_process = 2'd0;
    wait_dv(6, n);
    chk("io_latency", n, 2);
    chk("io_rpc", 32'(resume_pc), 100);
    chk("io_status", 32'(process_status), 32'b110111);

    ev_pulse(5, 0);
    wait_dv(6, n);
    chk("all_halt_no_dispatch", n, 7);
    chk("all_halted", 32'(all_halted), 1);
    chk("all_halt_status", 32'(process_status), 32'b111111);
    chk("not_dropped_yet", 32'(event_dropped), 0);
    ev_pulse(1, 0);
    wait_dv(6, n);
    chk("done_no_dispatch", n, 7);
    chk("done_dropped", 32'(event_dropped), 1);

    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    // Second rising edge lands while the FSM is busy.
    @(negedge clock); jump_enabler = 1'b1; state_register = 32'd2;
    @(negedge clock); jump_enabler = 1'b0;
    @(negedge clock); jump_enabler = 1'b1; state_register = 32'd3;
    @(negedge clock); jump_enabler = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (dispatch_valid) cnt++;
    end
    chk("busy_one_dispatch", cnt, 1);
    chk("busy_dropped", 32'(event_dropped), 1);
    chk("busy_rpc", 32'(resume_pc), 96);

    ev_pulse(1, 0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clock); reset = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (dispatch_valid) cnt++;
    end
    chk("mid_reset_no_dispatch", cnt, 0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      reset = ((m_phase == 4 && $urandom_range(0, 7) == 0) || $urandom_range(0, 999) == 0);
      jump_enabler    = ($urandom_range(0, 2) == 0);
      state_register  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
      program_counter = 12'($urandom);
      io_done         = ($urandom_range(0, 3) == 0);
      io_process      = 2'($urandom_range(0, 3));
    end
    @(negedge clock);
    reset = 1'b0; jump_enabler = 1'b0; io_done = 1'b0;
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
